// File: rtl/instr_queue_expander.sv
// Instruction queue with per-copy expansion: FIFO of control-unit pushes,
// issued one copy per cycle with strided cache / main-memory addresses.
module instr_queue_expander #(
  parameter int LOG_DEPTH             = 4,
  parameter int LOG_SUPERSCALAR_WIDTH = 3,
  parameter int ADDR_W                = 18
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           push_we,
  input  logic [1:0]                     push_instr_type,
  input  logic [LOG_SUPERSCALAR_WIDTH:0] push_copy_count,
  input  logic [8:0]                     push_arith_instr,
  input  logic [2:0]                     push_ram_instr,
  input  logic [6:0]                     push_ld_st_instr,
  input  logic [ADDR_W-1:0]              push_cache_addr,
  input  logic [ADDR_W-1:0]              push_main_mem_addr,
  input  logic [ADDR_W-1:0]              push_d_cache_addr,
  input  logic [ADDR_W-1:0]              push_d_main_mem_addr,
  output logic                           stall_push,
  output logic                           issue_valid,
  input  logic                           issue_ready,
  output logic [1:0]                     issue_instr_type,
  output logic [8:0]                     issue_arith_instr,
  output logic [2:0]                     issue_ram_instr,
  output logic [6:0]                     issue_ld_st_instr,
  output logic [ADDR_W-1:0]              issue_cache_addr,
  output logic [ADDR_W-1:0]              issue_main_mem_addr,
  output logic [LOG_SUPERSCALAR_WIDTH:0] issue_copy_index,
  output logic                           issue_last,
  output logic                           program_complete,
  output logic                           overflow_error
);

  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam int CW    = LOG_SUPERSCALAR_WIDTH + 1;
  localparam int OW    = LOG_DEPTH + 1;

  typedef enum logic {S_IDLE, S_EXPAND} state_t;

  logic [1:0]        r_q_type [DEPTH];
  logic [CW-1:0]     r_q_cc   [DEPTH];
  logic [8:0]        r_q_ar   [DEPTH];
  logic [2:0]        r_q_ram  [DEPTH];
  logic [6:0]        r_q_ls   [DEPTH];
  logic [ADDR_W-1:0] r_q_ca   [DEPTH];
  logic [ADDR_W-1:0] r_q_ma   [DEPTH];
  logic [ADDR_W-1:0] r_q_dca  [DEPTH];
  logic [ADDR_W-1:0] r_q_dma  [DEPTH];

  logic [LOG_DEPTH-1:0] r_wptr, r_rptr;
  logic [OW-1:0]        r_count;

  state_t            r_state;
  logic [CW-1:0]     r_k;
  logic [ADDR_W-1:0] r_acc_ca, r_acc_ma;
  logic [1:0]        r_type;
  logic [8:0]        r_ar;
  logic [2:0]        r_ram;
  logic [6:0]        r_ls;
  logic [ADDR_W-1:0] r_ca, r_ma;
  logic [CW-1:0]     r_idx;
  logic              r_last, r_pc, r_ovf;

  logic              w_empty, w_full, w_push, w_pop;
  logic              w_can_load, w_head_end, w_load;
  logic              w_pop_end, w_is_last;
  logic [CW-1:0]     w_cnt_eff;
  logic [ADDR_W-1:0] w_cur_ca, w_cur_ma;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == OW'(DEPTH));
  assign stall_push = (r_count >= OW'(DEPTH - 1));
  assign w_push     = push_we && !w_full;

  assign w_can_load = !issue_valid || issue_ready;
  assign w_head_end = !w_empty && (r_q_type[r_rptr] == 2'd3);
  assign w_pop_end  = w_can_load && w_head_end;
  assign w_load     = w_can_load && !w_empty && !w_head_end;

  assign w_cnt_eff = (r_q_cc[r_rptr] == '0) ? CW'(1) : r_q_cc[r_rptr];
  assign w_is_last = (r_k == w_cnt_eff - CW'(1));
  assign w_pop     = w_pop_end || (w_load && w_is_last);

  // Copy 0 takes the head's bases directly, so the accumulators never
  // need the next entry to be present at the moment the previous pops.
  assign w_cur_ca = (r_k == '0) ? r_q_ca[r_rptr] : r_acc_ca;
  assign w_cur_ma = (r_k == '0) ? r_q_ma[r_rptr] : r_acc_ma;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_type[r_wptr] <= push_instr_type;
      r_q_cc[r_wptr]   <= push_copy_count;
      r_q_ar[r_wptr]   <= push_arith_instr;
      r_q_ram[r_wptr]  <= push_ram_instr;
      r_q_ls[r_wptr]   <= push_ld_st_instr;
      r_q_ca[r_wptr]   <= push_cache_addr;
      r_q_ma[r_wptr]   <= push_main_mem_addr;
      r_q_dca[r_wptr]  <= push_d_cache_addr;
      r_q_dma[r_wptr]  <= push_d_main_mem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_acc_ca <= '0;
      r_acc_ma <= '0;
      r_type   <= '0;
      r_ar     <= '0;
      r_ram    <= '0;
      r_ls     <= '0;
      r_ca     <= '0;
      r_ma     <= '0;
      r_idx    <= '0;
      r_last   <= 1'b0;
      r_pc     <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_pc <= w_pop_end;
      if (push_we && w_full) r_ovf <= 1'b1;
      if (w_load) begin
        r_state <= S_EXPAND;
        r_type  <= r_q_type[r_rptr];
        r_ar    <= r_q_ar[r_rptr];
        r_ram   <= r_q_ram[r_rptr];
        r_ls    <= r_q_ls[r_rptr];
        r_ca    <= w_cur_ca;
        r_ma    <= w_cur_ma;
        r_idx   <= r_k;
        r_last  <= w_is_last;
        if (w_is_last) begin
          r_k      <= '0;
          r_acc_ca <= '0;
          r_acc_ma <= '0;
        end else begin
          r_k      <= r_k + CW'(1);
          r_acc_ca <= w_cur_ca + r_q_dca[r_rptr];
          r_acc_ma <= w_cur_ma + r_q_dma[r_rptr];
        end
      end else if (w_can_load) begin
        r_state <= S_IDLE;
      end
    end
  end

  assign issue_valid         = (r_state == S_EXPAND);
  assign issue_instr_type    = r_type;
  assign issue_arith_instr   = r_ar;
  assign issue_ram_instr     = r_ram;
  assign issue_ld_st_instr   = r_ls;
  assign issue_cache_addr    = r_ca;
  assign issue_main_mem_addr = r_ma;
  assign issue_copy_index    = r_idx;
  assign issue_last          = r_last;
  assign program_complete    = r_pc;
  assign overflow_error      = r_ovf;

endmodule

// File: tb/tb_instr_queue_expander.sv
// Bench for instr_queue_expander: vector table, scoreboard of expected
// beats, and hand sequences for handshake, overflow and reset corners.
module tb_instr_queue_expander;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        push_we = 1'b0;
  logic [1:0]  push_instr_type = '0;
  logic [3:0]  push_copy_count = '0;
  logic [8:0]  push_arith_instr = '0;
  logic [2:0]  push_ram_instr = '0;
  logic [6:0]  push_ld_st_instr = '0;
  logic [17:0] push_cache_addr = '0;
  logic [17:0] push_main_mem_addr = '0;
  logic [17:0] push_d_cache_addr = '0;
  logic [17:0] push_d_main_mem_addr = '0;
  logic        stall_push;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [1:0]  issue_instr_type;
  logic [8:0]  issue_arith_instr;
  logic [2:0]  issue_ram_instr;
  logic [6:0]  issue_ld_st_instr;
  logic [17:0] issue_cache_addr;
  logic [17:0] issue_main_mem_addr;
  logic [3:0]  issue_copy_index;
  logic        issue_last;
  logic        program_complete;
  logic        overflow_error;

  instr_queue_expander dut (
    .clk(clk), .reset_n(reset_n), .push_we(push_we),
    .push_instr_type(push_instr_type),
    .push_copy_count(push_copy_count),
    .push_arith_instr(push_arith_instr),
    .push_ram_instr(push_ram_instr),
    .push_ld_st_instr(push_ld_st_instr),
    .push_cache_addr(push_cache_addr),
    .push_main_mem_addr(push_main_mem_addr),
    .push_d_cache_addr(push_d_cache_addr),
    .push_d_main_mem_addr(push_d_main_mem_addr),
    .stall_push(stall_push), .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .issue_instr_type(issue_instr_type),
    .issue_arith_instr(issue_arith_instr),
    .issue_ram_instr(issue_ram_instr),
    .issue_ld_st_instr(issue_ld_st_instr),
    .issue_cache_addr(issue_cache_addr),
    .issue_main_mem_addr(issue_main_mem_addr),
    .issue_copy_index(issue_copy_index),
    .issue_last(issue_last),
    .program_complete(program_complete),
    .overflow_error(overflow_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  ty;
    logic [3:0]  cc;
    logic [8:0]  ar;
    logic [2:0]  ram;
    logic [6:0]  ls;
    logic [17:0] ca, dca, ma, dma;
    int          exp_n;
    logic [17:0] exp_lc, exp_lm;
  } vec_t;

  typedef struct {
    logic [1:0]  ty;
    logic [8:0]  ar;
    logic [2:0]  ram;
    logic [6:0]  ls;
    logic [17:0] ca, ma;
    logic [3:0]  idx;
    logic        last;
  } beat_t;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int n_beats = 0;
  int n_pulses = 0;
  int n_pe_exp = 0;
  logic [17:0] last_ca, last_ma;
  logic        hold_pend = 1'b0;
  logic [61:0] hold_snap;
  vec_t tv[5];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [61:0] pack_out();
    return {issue_instr_type, issue_arith_instr, issue_ram_instr,
            issue_ld_st_instr, issue_cache_addr, issue_main_mem_addr,
            issue_copy_index, issue_last};
  endfunction

  // Reference expansion uses base + k*delta rather than accumulation
  task automatic drive(input vec_t v, input bit accepted);
    logic [31:0] t;
    beat_t b;
    int n;
    push_we              = 1'b1;
    push_instr_type      = v.ty;
    push_copy_count      = v.cc;
    push_arith_instr     = v.ar;
    push_ram_instr       = v.ram;
    push_ld_st_instr     = v.ls;
    push_cache_addr      = v.ca;
    push_main_mem_addr   = v.ma;
    push_d_cache_addr    = v.dca;
    push_d_main_mem_addr = v.dma;
    if (accepted) begin
      if (v.ty == 2'd3) n_pe_exp++;
      else begin
        n = (v.cc == 4'd0) ? 1 : int'(v.cc);
        for (int k = 0; k < n; k++) begin
          b.ty = v.ty; b.ar = v.ar; b.ram = v.ram; b.ls = v.ls;
          t = 32'(v.ca) + 32'(k) * 32'(v.dca);
          b.ca = t[17:0];
          t = 32'(v.ma) + 32'(k) * 32'(v.dma);
          b.ma = t[17:0];
          b.idx = 4'(k);
          b.last = (k == n - 1);
          sb.push_back(b);
        end
      end
    end
    @(posedge clk); #1;
    push_we = 1'b0;
  endtask

  task automatic drain(input int budget);
    int c;
    c = 0;
    while ((sb.size() != 0 || issue_valid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain_timeout", 64'(c < budget), 64'(1));
  endtask

  function automatic vec_t mk(input logic [1:0] ty, input logic [3:0] cc,
                              input logic [17:0] ca, input logic [17:0] dca,
                              input logic [17:0] ma, input logic [17:0] dma);
    vec_t v;
    v.ty = ty; v.cc = cc; v.ar = 9'h0C3; v.ram = 3'b110; v.ls = 7'h2D;
    v.ca = ca; v.dca = dca; v.ma = ma; v.dma = dma;
    v.exp_n = 0; v.exp_lc = '0; v.exp_lm = '0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!reset_n) hold_pend = 1'b0;
    else begin
      if (hold_pend)
        chk("hold_stable", 64'({issue_valid, pack_out()}),
            64'({1'b1, hold_snap}));
      if (issue_valid && issue_ready) begin
        if (sb.size() == 0) chk("unexpected_issue", 64'(1), 64'(0));
        else begin
          beat_t e;
          e = sb.pop_front();
          chk("beat", 64'(pack_out()),
              64'({e.ty, e.ar, e.ram, e.ls, e.ca, e.ma, e.idx, e.last}));
        end
        n_beats++;
        last_ca = issue_cache_addr;
        last_ma = issue_main_mem_addr;
      end
      hold_pend = issue_valid && !issue_ready;
      hold_snap = pack_out();
      if (program_complete) begin
        n_pulses++;
        chk("pc_after_copies", 64'(sb.size()), 64'(0));
      end
    end
  end

  initial begin
    vec_t v;
    int p0;
    tv[0] = mk(2'd2, 4'd1, 18'd5, 18'd3, 18'd7, 18'd1);
    tv[0].ar = 9'h1A5; tv[0].exp_n = 1;
    tv[0].exp_lc = 18'd5; tv[0].exp_lm = 18'd7;
    tv[1] = mk(2'd1, 4'd8, 18'd100, 18'd4, 18'h3FFFE, 18'd1);
    tv[1].ram = 3'b101; tv[1].exp_n = 8;
    tv[1].exp_lc = 18'd128; tv[1].exp_lm = 18'h00005;
    tv[2] = mk(2'd0, 4'd3, 18'h3FFF0, 18'h10, 18'd1000, 18'h3FFFF);
    tv[2].ls = 7'h5B; tv[2].exp_n = 3;
    tv[2].exp_lc = 18'h10; tv[2].exp_lm = 18'd998;
    tv[3] = mk(2'd2, 4'd0, 18'd42, 18'd7, 18'd9, 18'd9);
    tv[3].exp_n = 1; tv[3].exp_lc = 18'd42; tv[3].exp_lm = 18'd9;
    tv[4] = mk(2'd2, 4'd2, 18'd0, 18'h20000, 18'h1FFFF, 18'h20001);
    tv[4].exp_n = 2; tv[4].exp_lc = 18'h20000; tv[4].exp_lm = 18'd0;

    #12;
    chk("rst_valid", 64'(issue_valid), 64'(0));
    chk("rst_outs", 64'(pack_out()), 64'(0));
    chk("rst_flags", 64'({stall_push, program_complete, overflow_error}),
        64'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // first-issue latency
    issue_ready = 1'b1;
    v = mk(2'd2, 4'd1, 18'd11, 18'd0, 18'd22, 18'd0);
    drive(v, 1'b1);
    chk("lat_edge_n", 64'(issue_valid), 64'(0));
    @(posedge clk); #1;
    chk("lat_edge_n1", 64'({issue_valid, issue_last, issue_copy_index}),
        64'({1'b1, 1'b1, 4'd0}));
    drain(20);

    for (int i = 0; i < 5; i++) begin
      n_beats = 0;
      drive(tv[i], 1'b1);
      drain(40);
      chk($sformatf("vec%0d_n", i), 64'(n_beats), 64'(tv[i].exp_n));
      chk($sformatf("vec%0d_last", i), 64'({last_ca, last_ma}),
          64'({tv[i].exp_lc, tv[i].exp_lm}));
    end

    // copy_count=3 then PROG_END under toggling ready
    issue_ready = 1'b0;
    p0 = n_pulses;
    drive(mk(2'd0, 4'd3, 18'd50, 18'd2, 18'd60, 18'd3), 1'b1);
    drive(mk(2'd3, 4'd5, 18'd0, 18'd0, 18'd0, 18'd0), 1'b1);
    begin
      logic [4:0] pat;
      pat = 5'b10101;
      for (int i = 4; i >= 0; i--) begin
        issue_ready = pat[i];
        @(posedge clk); #1;
        if (i == 2) chk("pc_early", 64'(n_pulses - p0), 64'(0));
      end
    end
    issue_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("pc_once", 64'(n_pulses - p0), 64'(1));

    // back-to-back PROG_END
    p0 = n_pulses;
    drive(mk(2'd3, 4'd1, 18'd0, 18'd0, 18'd0, 18'd0), 1'b1);
    drive(mk(2'd3, 4'd2, 18'd0, 18'd0, 18'd0, 18'd0), 1'b1);
    @(posedge clk); #1;
    chk("pc_b2b_first", 64'(program_complete), 64'(1));
    repeat (3) begin @(posedge clk); #1; end
    chk("pc_b2b_count", 64'(n_pulses - p0), 64'(2));

    // fill with ready low: entry 0 sits in the issue register
    issue_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(mk(2'd2, 4'd1, 18'(1000 + i), 18'd0, 18'(i), 18'd0), i < 17);
      if (i == 14) chk("stall_occ14", 64'(stall_push), 64'(0));
      if (i == 15) chk("stall_occ15", 64'(stall_push), 64'(1));
      if (i == 16) chk("ovf_before", 64'(overflow_error), 64'(0));
      if (i == 17) chk("ovf_set", 64'(overflow_error), 64'(1));
    end
    n_beats = 0;
    issue_ready = 1'b1;
    drain(60);
    chk("ovf_issued", 64'(n_beats), 64'(17));
    chk("ovf_sticky", 64'({overflow_error, stall_push}), 64'({1'b1, 1'b0}));

    // async reset mid-expansion
    drive(mk(2'd1, 4'd8, 18'd7, 18'd1, 18'd8, 18'd1), 1'b1);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    reset_n = 1'b0;
    sb.delete();
    #1;
    chk("arst_valid", 64'(issue_valid), 64'(0));
    chk("arst_outs", 64'(pack_out()), 64'(0));
    chk("arst_flags", 64'({stall_push, program_complete, overflow_error}),
        64'(0));
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b1;
    n_beats = 0;
    repeat (10) begin @(posedge clk); #1; end
    chk("post_rst_idle", 64'({issue_valid, stall_push}), 64'(0));
    chk("post_rst_beats", 64'(n_beats), 64'(0));

    chk("sb_empty", 64'(sb.size()), 64'(0));
    chk("pc_total", 64'(n_pulses), 64'(n_pe_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
